// File: rtl/cpld_chain_if.sv
// Serial bridge to the board CPLD: shifts LED/7-segment frames out on cpld_mosi
// and captures the CPLD switch word from cpld_miso in the same frames.
module cpld_chain_if #(
   parameter int LED_W    = 8,
   parameter int N_DIG    = 2,
   parameter int IN_W     = 16,
   parameter int HALF_DIV = 512
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [LED_W-1:0]     led,
   input  logic [4*N_DIG-1:0]   dig,
   input  logic [N_DIG-1:0]     dp,
   input  logic [N_DIG-1:0]     blank,
   output logic [IN_W-1:0]      sw_out,
   output logic                 sw_valid,
   output logic                 sw_changed,
   output logic                 cpld_rstn,
   output logic                 cpld_clk,
   output logic                 cpld_load,
   output logic                 cpld_mosi,
   input  logic                 cpld_miso
);

   localparam int OUT_W     = LED_W + 8 + N_DIG;
   localparam int FRAME_LEN = (OUT_W > IN_W) ? OUT_W : IN_W;
   localparam int PH_W      = $clog2(2 * HALF_DIV);
   localparam int BIT_W     = $clog2(FRAME_LEN);
   localparam int DSEL_W    = (N_DIG > 1) ? $clog2(N_DIG) : 1;

   localparam logic [PH_W-1:0]   PH_RISE   = PH_W'(HALF_DIV - 1);
   localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(2 * HALF_DIV - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_LEN - 1);
   localparam logic [DSEL_W-1:0] DSEL_LAST = DSEL_W'(N_DIG - 1);

   typedef enum logic {S_RESET, S_SHIFT} state_t;

   state_t                 state;
   logic [PH_W-1:0]        phase;
   logic [BIT_W-1:0]       bit_idx;
   logic [DSEL_W-1:0]      dsel;
   logic [FRAME_LEN-1:0]   frame_p0;
   logic [IN_W-1:0]        sh_p0;

   logic [DSEL_W-1:0]      dsel_wrap;
   logic [DSEL_W-1:0]      snap_sel;
   logic [3:0]             snap_dig;
   logic [N_DIG-1:0]       snap_dp;
   logic [N_DIG-1:0]       snap_blank;
   logic [FRAME_LEN-1:0]   next_frame;
   logic [IN_W-1:0]        sh_next;
   logic [BIT_W-1:0]       bit_nxt;
   logic                   sample;
   logic                   frame_end;
   logic                   load_frame;

   function automatic logic [6:0] hex_seg(input logic [3:0] v);
      case (v)
         4'h0: hex_seg = 7'h3F;
         4'h1: hex_seg = 7'h06;
         4'h2: hex_seg = 7'h5B;
         4'h3: hex_seg = 7'h4F;
         4'h4: hex_seg = 7'h66;
         4'h5: hex_seg = 7'h6D;
         4'h6: hex_seg = 7'h7D;
         4'h7: hex_seg = 7'h07;
         4'h8: hex_seg = 7'h7F;
         4'h9: hex_seg = 7'h6F;
         4'hA: hex_seg = 7'h77;
         4'hB: hex_seg = 7'h7C;
         4'hC: hex_seg = 7'h39;
         4'hD: hex_seg = 7'h5E;
         4'hE: hex_seg = 7'h79;
         default: hex_seg = 7'h71;
      endcase
   endfunction

   // Frame layout, LSB first: LED bits, segment byte, one-hot digit enable, zero pad.
   function automatic logic [FRAME_LEN-1:0] build_frame(
      input logic [LED_W-1:0]  l,
      input logic [3:0]        d,
      input logic              p,
      input logic              b,
      input logic [DSEL_W-1:0] sel
   );
      logic [FRAME_LEN-1:0] f;
      logic [7:0]           seg;
      logic [N_DIG-1:0]     en;
      seg = b ? 8'h00 : {p, hex_seg(d)};
      en  = N_DIG'(1) << sel;
      f   = '0;
      f[LED_W-1:0]         = l;
      f[LED_W +: 8]        = seg;
      f[LED_W + 8 +: N_DIG] = en;
      return f;
   endfunction

   assign cpld_rstn = ~rst;

   always_comb begin
      dsel_wrap  = (dsel == DSEL_LAST) ? '0 : dsel + 1'b1;
      snap_sel   = (state == S_RESET) ? '0 : dsel_wrap;
      snap_dig   = 4'(dig >> {snap_sel, 2'b00});
      snap_dp    = dp >> snap_sel;
      snap_blank = blank >> snap_sel;
      next_frame = build_frame(led, snap_dig, snap_dp[0], snap_blank[0], snap_sel);
      sh_next          = sh_p0 >> 1;
      sh_next[IN_W-1]  = cpld_miso;
      bit_nxt    = bit_idx + 1'b1;
      sample     = !rst && (state == S_SHIFT) && (phase == PH_LAST);
      frame_end  = sample && (bit_idx == BIT_LAST);
      load_frame = (!rst && (state == S_RESET)) || frame_end;
   end

   // Data registers: frame snapshot and input shifter carry no reset; every
   // frame fully overwrites the shifter before it is published.
   always_ff @(posedge clk) begin
      if (load_frame) frame_p0 <= next_frame;
      if (sample)     sh_p0    <= sh_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_RESET;
         phase      <= '0;
         bit_idx    <= '0;
         dsel       <= '0;
         cpld_clk   <= 1'b0;
         cpld_load  <= 1'b0;
         cpld_mosi  <= 1'b0;
         sw_out     <= '0;
         sw_valid   <= 1'b0;
         sw_changed <= 1'b0;
      end else begin
         sw_valid   <= 1'b0;
         sw_changed <= 1'b0;
         case (state)
            S_RESET: begin
               state     <= S_SHIFT;
               phase     <= '0;
               bit_idx   <= '0;
               dsel      <= '0;
               cpld_mosi <= next_frame[0];
               cpld_load <= 1'b0;
            end
            S_SHIFT: begin
               if (phase == PH_RISE) cpld_clk <= 1'b1;
               if (phase == PH_LAST) begin
                  cpld_clk <= 1'b0;
                  phase    <= '0;
                  if (bit_idx == BIT_LAST) begin
                     bit_idx    <= '0;
                     dsel       <= dsel_wrap;
                     cpld_mosi  <= next_frame[0];
                     cpld_load  <= 1'b0;
                     sw_out     <= sh_next;
                     sw_valid   <= 1'b1;
                     sw_changed <= (sh_next != sw_out);
                  end else begin
                     bit_idx   <= bit_nxt;
                     cpld_mosi <= frame_p0[bit_nxt];
                     cpld_load <= (bit_nxt == BIT_LAST);
                  end
               end else begin
                  phase <= phase + 1'b1;
               end
            end
            default: state <= S_RESET;
         endcase
      end
   end

endmodule

// File: tb/tb_cpld_chain_if.sv
// Directed bench for cpld_chain_if: frame-table checks on a default-width
// instance plus a 32-bit-input instance, with a pin-level CPLD model.
module tb_cpld_chain_if;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst1 = 1'b1;
   logic rst2 = 1'b1;

   logic [7:0]  led1;
   logic [7:0]  dig1;
   logic [1:0]  dp1, blank1;
   logic [15:0] sw1;
   logic        v1, c1, rstn1, ck1, ld1, mosi1, miso1;

   logic [3:0]  led2;
   logic [3:0]  dig2;
   logic [0:0]  dp2, blank2;
   logic [31:0] sw2;
   logic        v2, c2, rstn2, ck2, ld2, mosi2, miso2;

   cpld_chain_if #(.LED_W(8), .N_DIG(2), .IN_W(16), .HALF_DIV(2)) dut1 (
      .clk(clk), .rst(rst1), .led(led1), .dig(dig1), .dp(dp1), .blank(blank1),
      .sw_out(sw1), .sw_valid(v1), .sw_changed(c1), .cpld_rstn(rstn1),
      .cpld_clk(ck1), .cpld_load(ld1), .cpld_mosi(mosi1), .cpld_miso(miso1));

   cpld_chain_if #(.LED_W(4), .N_DIG(1), .IN_W(32), .HALF_DIV(2)) dut2 (
      .clk(clk), .rst(rst2), .led(led2), .dig(dig2), .dp(dp2), .blank(blank2),
      .sw_out(sw2), .sw_valid(v2), .sw_changed(c2), .cpld_rstn(rstn2),
      .cpld_clk(ck2), .cpld_load(ld2), .cpld_mosi(mosi2), .cpld_miso(miso2));

   // CPLD models: advance one bit on each cpld_clk fall, restart after the load period.
   logic [15:0] word1 = 16'hBEEF;
   logic [31:0] word2 = 32'h12345678;
   int   mb1 = 0, mb2 = 0;
   logic pc1 = 1'b0, pl1 = 1'b0, pc2 = 1'b0, pl2 = 1'b0;

   always @(negedge clk or posedge rst1) begin
      if (rst1) mb1 <= 0;
      else if (pc1 && !ck1) mb1 <= pl1 ? 0 : mb1 + 1;
      pc1 <= ck1;
      pl1 <= ld1;
   end
   assign miso1 = (mb1 < 2) ? 1'b1 : word1[mb1-2];

   always @(negedge clk or posedge rst2) begin
      if (rst2) mb2 <= 0;
      else if (pc2 && !ck2) mb2 <= pl2 ? 0 : mb2 + 1;
      pc2 <= ck2;
      pl2 <= ld2;
   end
   assign miso2 = word2[mb2];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cap(input bit sel, input int fl, input int chg_bit, input logic [7:0] chg_led,
                      output logic [31:0] mo, output logic [31:0] ld, output int herr,
                      output logic v0, output logic c0, output logic [31:0] so0, output int vother);
      logic m, l, ck, v, c, mf, lf;
      logic [31:0] so;
      mo = '0; ld = '0; herr = 0; vother = 0; v0 = 1'b0; c0 = 1'b0; so0 = '0; mf = 1'b0; lf = 1'b0;
      for (int b = 0; b < fl; b++) begin
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (b == chg_bit && k == 1) led1 = chg_led;
            m  = sel ? mosi2 : mosi1;
            l  = sel ? ld2 : ld1;
            ck = sel ? ck2 : ck1;
            v  = sel ? v2 : v1;
            c  = sel ? c2 : c1;
            so = sel ? sw2 : {16'h0, sw1};
            if (k == 0) begin
               mo[b] = m; ld[b] = l; mf = m; lf = l;
            end else if (m !== mf || l !== lf) herr++;
            if (ck !== (k >= 2)) herr++;
            if (b == 0 && k == 0) begin
               v0 = v; c0 = c; so0 = so;
            end else if (v !== 1'b0 || c !== 1'b0) vother++;
         end
      end
   endtask

   task automatic frame(input string tag, input bit sel, input int fl, input int chg_bit,
                        input logic [7:0] chg_led, input logic [31:0] exp_mo,
                        input logic exp_v0, input logic exp_c0, input logic [31:0] exp_so);
      logic [31:0] mo, ld, so0;
      int herr, vother;
      logic v0, c0;
      cap(sel, fl, chg_bit, chg_led, mo, ld, herr, v0, c0, so0, vother);
      chk({tag, "_mosi"}, mo, exp_mo);
      chk({tag, "_load"}, ld, 32'd1 << (fl - 1));
      chk({tag, "_hold"}, herr, 0);
      chk({tag, "_valid"}, {31'b0, v0}, {31'b0, exp_v0});
      chk({tag, "_changed"}, {31'b0, c0}, {31'b0, exp_c0});
      chk({tag, "_swout"}, so0, exp_so);
      chk({tag, "_stray_strobe"}, vother, 0);
   endtask

   typedef struct {
      logic [7:0]  led;
      logic [7:0]  dig;
      logic [1:0]  dp;
      logic [1:0]  blank;
      logic [31:0] mo;
      logic        v0;
      logic        c0;
      logic [31:0] so;
   } vec_t;

   vec_t tbl[4];

   initial begin
      tbl[0] = '{8'hA5, 8'h31, 2'b00, 2'b00, 32'h106A5, 1'b0, 1'b0, 32'h0};
      tbl[1] = '{8'hA5, 8'h31, 2'b00, 2'b00, 32'h24FA5, 1'b1, 1'b1, 32'hBEEF};
      tbl[2] = '{8'hA5, 8'h88, 2'b11, 2'b01, 32'h100A5, 1'b1, 1'b0, 32'hBEEF};
      tbl[3] = '{8'hA5, 8'h88, 2'b11, 2'b01, 32'h2FFA5, 1'b1, 1'b0, 32'hBEEF};

      led1 = 8'h00; dig1 = 8'h00; dp1 = 2'b00; blank1 = 2'b00;
      led2 = 4'h0;  dig2 = 4'h0;  dp2 = 1'b0;  blank2 = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_swout", {16'h0, sw1}, 32'h0);
      chk("rst_valid", {31'b0, v1}, 32'h0);
      chk("rst_changed", {31'b0, c1}, 32'h0);
      chk("rst_cpld_clk", {31'b0, ck1}, 32'h0);
      chk("rst_load", {31'b0, ld1}, 32'h0);
      chk("rst_mosi", {31'b0, mosi1}, 32'h0);
      chk("rst_rstn", {31'b0, rstn1}, 32'h0);
      chk("rst2_swout", sw2, 32'h0);
      chk("rst2_rstn", {31'b0, rstn2}, 32'h0);

      for (int i = 0; i < 4; i++) begin
         led1 = tbl[i].led; dig1 = tbl[i].dig; dp1 = tbl[i].dp; blank1 = tbl[i].blank;
         if (i == 0) rst1 = 1'b0;
         frame($sformatf("tbl%0d", i), 1'b0, 18, -1, 8'h00, tbl[i].mo, tbl[i].v0, tbl[i].c0, tbl[i].so);
      end

      // LED change during bit period 3 must not reach the current frame.
      led1 = 8'h00; dig1 = 8'h31; dp1 = 2'b00; blank1 = 2'b00;
      frame("led_mid", 1'b0, 18, 3, 8'hFF, 32'h10600, 1'b1, 1'b0, 32'hBEEF);
      frame("led_next", 1'b0, 18, -1, 8'h00, 32'h24FFF, 1'b1, 1'b0, 32'hBEEF);

      // One-cycle reset in bit period 10.
      repeat (41) @(negedge clk);
      chk("pre_rst_swout", {16'h0, sw1}, 32'hBEEF);
      chk("pre_rst_mosi", {31'b0, mosi1}, 32'h1);
      rst1 = 1'b1;
      @(negedge clk);
      chk("mid_rst_swout", {16'h0, sw1}, 32'h0);
      chk("mid_rst_valid", {31'b0, v1}, 32'h0);
      chk("mid_rst_cpld_clk", {31'b0, ck1}, 32'h0);
      chk("mid_rst_load", {31'b0, ld1}, 32'h0);
      chk("mid_rst_mosi", {31'b0, mosi1}, 32'h0);
      chk("mid_rst_rstn", {31'b0, rstn1}, 32'h0);
      rst1 = 1'b0;
      #1;
      chk("run_rstn", {31'b0, rstn1}, 32'h1);
      frame("restart", 1'b0, 18, -1, 8'h00, 32'h106FF, 1'b0, 1'b0, 32'h0);
      frame("restart_next", 1'b0, 18, -1, 8'h00, 32'h24FFF, 1'b1, 1'b1, 32'hBEEF);

      // Wide-input instance: zero padding above OUT_W and 32-bit capture.
      led2 = 4'h9; dig2 = 4'h5; dp2 = 1'b1; blank2 = 1'b0;
      rst2 = 1'b0;
      frame("w32_f0", 1'b1, 32, -1, 8'h00, 32'h00001ED9, 1'b0, 1'b0, 32'h0);
      frame("w32_f1", 1'b1, 32, -1, 8'h00, 32'h00001ED9, 1'b1, 1'b1, 32'h12345678);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
